xif_host_offloader: RTL
=======================

Name: xif_host_offloader

Overview:
- CPU-side endpoint of the CORE-V-XIF issue, commit and result channels; the host counterpart to the rvfpm coprocessor ports.
- Accepts instructions from an upstream valid/ready stream and assigns each a rolling ID.
- Drives the issue handshake, sends commit or kill the cycle after each accept, tracks outstanding IDs and returns results as one-cycle writeback pulses.
- Used as the integration host in system benches and as the reference driver for coprocessor verification.

Parameters:
- X_ID_WIDTH, 4, width of the instruction ID field.
- X_NUM_RS, 2, number of source operands carried in the issue request.
- X_RFR_WIDTH, 32, width of each source operand.
- X_RFW_WIDTH, 32, result data width.
- XLEN, 32, integer register width; the result write-enable width is X_RFW_WIDTH/XLEN.
- MAX_OUTSTANDING, 4, maximum number of accepted-but-uncompleted instructions; range 1..2**X_ID_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous assert, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  upstream instruction ready.
- in_instr  in  32  instruction word.
- in_rs  in  X_NUM_RS*X_RFR_WIDTH  source operands.
- in_kill  in  1  kill this instruction at commit.
- issue_valid  out  1  XIF issue valid.
- issue_ready  in  1  XIF issue ready.
- issue_instr  out  32  issued instruction.
- issue_id  out  X_ID_WIDTH  issued ID.
- issue_rs  out  X_NUM_RS*X_RFR_WIDTH  issued operands.
- issue_rs_valid  out  X_NUM_RS  operand valid flags, all ones.
- issue_accept  in  1  coprocessor accepted the instruction.
- issue_writeback  in  1  coprocessor will produce a result.
- commit_valid  out  1  XIF commit valid.
- commit_id  out  X_ID_WIDTH  committed ID.
- commit_kill  out  1  kill flag for the committed ID.
- result_valid  in  1  XIF result valid.
- result_ready  out  1  XIF result ready.
- result_id  in  X_ID_WIDTH  result ID.
- result_data  in  X_RFW_WIDTH  result data.
- result_rd  in  5  destination register.
- result_we  in  X_RFW_WIDTH/XLEN  register write enable.
- result_exc  in  1  result carries an exception.
- wb_valid  out  1  writeback pulse.
- wb_rd  out  5  writeback destination register.
- wb_data  out  X_RFW_WIDTH  writeback data.
- wb_exc  out  1  writeback exception flag.
- reject_pulse  out  1  last issue was not accepted.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  number of live IDs.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset values: every output is 0, next_id = 0, outstanding bitmap = 0, FSM in IDLE.
- FSM states: IDLE, ISSUE, COMMIT.
- IDLE:
  - in_ready = 1 only when outstanding < MAX_OUTSTANDING and the bit for next_id is clear.
  - On in_valid && in_ready, latch instr, rs and kill, then go to ISSUE.
- ISSUE:
  - issue_valid = 1; instr, id and rs are held stable until issue_valid && issue_ready.
  - On that handshake, if issue_accept = 1:
    - set the bitmap bit for the ID;
    - record whether a writeback is expected (issue_writeback);
    - go to COMMIT.
  - On that handshake, if issue_accept = 0:
    - reject_pulse = 1 for one cycle; no commit is sent; go to IDLE.
  - next_id increments modulo 2**X_ID_WIDTH on every issue handshake, accepted or not.
- COMMIT:
  - commit_valid = 1 for exactly one cycle with the latched ID and kill flag; then go to IDLE.
  - The bit is cleared in that same cycle if the kill flag is set or no writeback was expected.
- Issue-to-commit latency is exactly one cycle; back-to-back issues occur at most every 3 cycles.
- Results:
  - result_ready = 1 whenever not in reset.
  - On result_valid && result_ready with the ID bit set and its commit already sent:
    - clear the bit;
    - next cycle drive wb_valid = 1 for one cycle with rd, data and exc;
    - wb_valid = 0 if result_we = 0.
  - A result whose ID bit is clear, or whose commit is not yet sent, or that arrives for a killed ID, sets proto_err and is otherwise dropped.
- Simultaneous events:
  - A set and a clear of the bitmap in the same cycle apply to different IDs and must both take effect.
  - outstanding is recomputed from the net change in the same cycle.
- Reset asserted mid-operation clears all state immediately; in-flight IDs are forgotten.

Test Plan:
- Single accepted instruction: in_instr=0x00B50553, issue_ready=1, accept=1, writeback=1.
  - Expect issue_id=0, then commit_valid one cycle later with id=0 and kill=0.
  - Then result id=0, data=0x3F800000, rd=10, we=1 → wb_valid pulse with rd=10, data=0x3F800000; outstanding returns to 0.
- Issue stall: issue_ready held 0 for 5 cycles → issue_valid and all issue fields stay stable; in_ready=0 throughout.
- Reject: accept=0 → reject_pulse one cycle, no commit_valid, next instruction gets id=1, outstanding stays 0.
- Kill: in_kill=1 and accepted → commit_kill=1 and the ID is freed at commit.
  - A later result carrying that ID sets proto_err; no wb_valid.
- Full window: issue 4 accepted instructions with no results → outstanding=4 and in_ready=0.
  - A result for id=2 → in_ready returns to 1; wraparound to id=0 only after id=0 completes.
- Reset during ISSUE: all outputs go to 0 asynchronously; the next issue after release uses id=0.

Source files
------------

// File: rtl/xif_host_offloader.sv
// Host side of CORE-V-XIF: takes upstream instructions, issues with rolling IDs, commits one cycle after accept, returns results as wb pulses.
// Backpressure: in_ready drops while an instruction is in flight, the ID window is full, or the next ID is still live; results are always accepted.
module xif_host_offloader #(
  parameter int X_ID_WIDTH      = 4,
  parameter int X_NUM_RS        = 2,
  parameter int X_RFR_WIDTH     = 32,
  parameter int X_RFW_WIDTH     = 32,
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  input  logic [X_NUM_RS*X_RFR_WIDTH-1:0]    in_rs,
  input  logic                               in_kill,
  output logic                               issue_valid,
  input  logic                               issue_ready,
  output logic [31:0]                        issue_instr,
  output logic [X_ID_WIDTH-1:0]              issue_id,
  output logic [X_NUM_RS*X_RFR_WIDTH-1:0]    issue_rs,
  output logic [X_NUM_RS-1:0]                issue_rs_valid,
  input  logic                               issue_accept,
  input  logic                               issue_writeback,
  output logic                               commit_valid,
  output logic [X_ID_WIDTH-1:0]              commit_id,
  output logic                               commit_kill,
  input  logic                               result_valid,
  output logic                               result_ready,
  input  logic [X_ID_WIDTH-1:0]              result_id,
  input  logic [X_RFW_WIDTH-1:0]             result_data,
  input  logic [4:0]                         result_rd,
  input  logic [X_RFW_WIDTH/XLEN-1:0]        result_we,
  input  logic                               result_exc,
  output logic                               wb_valid,
  output logic [4:0]                         wb_rd,
  output logic [X_RFW_WIDTH-1:0]             wb_data,
  output logic                               wb_exc,
  output logic                               reject_pulse,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               proto_err
);
  localparam int NID = 1 << X_ID_WIDTH;
  localparam int RSW = X_NUM_RS * X_RFR_WIDTH;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, COMMIT} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [RSW-1:0]         rs_q, rs_d;
  logic                   kill_q, kill_d, wb_exp_q, wb_exp_d;
  logic [X_ID_WIDTH-1:0]  id_q, id_d, next_id_q, next_id_d;
  logic [NID-1:0]         bitmap_q, bitmap_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   in_ready_q, in_ready_d, issue_valid_q, issue_valid_d;
  logic                   commit_valid_q, commit_valid_d, commit_kill_q, commit_kill_d;
  logic [X_ID_WIDTH-1:0]  commit_id_q, commit_id_d;
  logic                   reject_q, reject_d, proto_err_q, proto_err_d;
  logic                   wb_valid_q, wb_valid_d, wb_exc_q, wb_exc_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [X_RFW_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                   set_bit, clr_cmt, clr_res, res_ok;

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    rs_d           = rs_q;
    kill_d         = kill_q;
    id_d           = id_q;
    next_id_d      = next_id_q;
    wb_exp_d       = wb_exp_q;
    issue_valid_d  = issue_valid_q;
    commit_valid_d = 1'b0;
    commit_id_d    = '0;
    commit_kill_d  = 1'b0;
    reject_d       = 1'b0;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_exc_d       = wb_exc_q;
    proto_err_d    = proto_err_q;
    set_bit        = 1'b0;
    clr_cmt        = 1'b0;
    clr_res        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          instr_d       = in_instr;
          rs_d          = in_rs;
          kill_d        = in_kill;
          id_d          = next_id_q;
          issue_valid_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          issue_valid_d = 1'b0;
          next_id_d     = next_id_q + X_ID_WIDTH'(1);
          if (issue_accept) begin
            set_bit        = 1'b1;
            wb_exp_d       = issue_writeback;
            commit_valid_d = 1'b1;
            commit_id_d    = id_q;
            commit_kill_d  = kill_q;
            state_d        = COMMIT;
          end else begin
            reject_d = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      COMMIT: begin
        clr_cmt = kill_q | ~wb_exp_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The ID being committed this cycle has not had its commit seen yet.
    res_ok = bitmap_q[result_id] && !(state_q == COMMIT && result_id == id_q);
    if (result_valid && result_ready) begin
      if (res_ok) begin
        clr_res    = 1'b1;
        wb_valid_d = |result_we;
        wb_rd_d    = result_rd;
        wb_data_d  = result_data;
        wb_exc_d   = result_exc;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    bitmap_d = bitmap_q;
    if (set_bit) bitmap_d[id_q] = 1'b1;
    if (clr_cmt) bitmap_d[id_q] = 1'b0;
    if (clr_res) bitmap_d[result_id] = 1'b0;
    cnt_d = cnt_q + CW'(set_bit) - CW'(clr_cmt) - CW'(clr_res);

    in_ready_d = (state_d == IDLE) && (cnt_d < CW'(MAX_OUTSTANDING)) && !bitmap_d[next_id_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      rs_q           <= '0;
      kill_q         <= 1'b0;
      id_q           <= '0;
      next_id_q      <= '0;
      wb_exp_q       <= 1'b0;
      bitmap_q       <= '0;
      cnt_q          <= '0;
      in_ready_q     <= 1'b0;
      issue_valid_q  <= 1'b0;
      commit_valid_q <= 1'b0;
      commit_id_q    <= '0;
      commit_kill_q  <= 1'b0;
      reject_q       <= 1'b0;
      proto_err_q    <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      wb_exc_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      rs_q           <= rs_d;
      kill_q         <= kill_d;
      id_q           <= id_d;
      next_id_q      <= next_id_d;
      wb_exp_q       <= wb_exp_d;
      bitmap_q       <= bitmap_d;
      cnt_q          <= cnt_d;
      in_ready_q     <= in_ready_d;
      issue_valid_q  <= issue_valid_d;
      commit_valid_q <= commit_valid_d;
      commit_id_q    <= commit_id_d;
      commit_kill_q  <= commit_kill_d;
      reject_q       <= reject_d;
      proto_err_q    <= proto_err_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_exc_q       <= wb_exc_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign issue_valid    = issue_valid_q;
  assign issue_instr    = instr_q;
  assign issue_id       = id_q;
  assign issue_rs       = rs_q;
  assign issue_rs_valid = {X_NUM_RS{issue_valid_q}};
  assign commit_valid   = commit_valid_q;
  assign commit_id      = commit_id_q;
  assign commit_kill    = commit_kill_q;
  assign result_ready   = ~rst;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign wb_exc         = wb_exc_q;
  assign reject_pulse   = reject_q;
  assign outstanding    = cnt_q;
  assign proto_err      = proto_err_q;
endmodule
